// File: rtl/mul_pipe_unit_pkg.sv
// -----------------------------------------------------------------------------
// mul_pipe_unit_pkg
// Shared definitions for the pipelined multiply functional unit:
//   - clog2()       : ceiling log2 used to size the reduction tree
//   - MODE_SIGNED / MODE_HIGH : mode bit positions in the reservation-station
//                     encoding of a multiply operation
//   - SIDE_*        : layout of the sideband word that travels with each
//                     operation down the pipe ({tag, high, neg})
// -----------------------------------------------------------------------------
package mul_pipe_unit_pkg;

   localparam int MODE_SIGNED = 0;
   localparam int MODE_HIGH   = 1;
   localparam int MODE_W      = 2;

   localparam int SIDE_NEG    = 0;
   localparam int SIDE_HIGH   = 1;
   localparam int SIDE_TAG    = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_pipe_unit_reduce.sv
// -----------------------------------------------------------------------------
// mul_reduce_stage
// One registered level of the partial-product adder tree. Input i is added to
// input i+N/2, so N operands become N/2 registered sums. The valid bit and the
// sideband word are registered alongside so they stay aligned with the data.
// Ports:
//   clk, nRST        clock, asynchronous active-low reset
//   hold_i           1 = keep current contents (output stalled)
//   flush_i          1 = drop the valid bit on this edge
//   valid_i/side_i   valid and sideband from the previous level
//   pp_i             N operands of DW bits, flattened (operand i at i*DW)
//   valid_o/side_o   registered valid and sideband
//   sum_o            N/2 registered sums of DW bits, flattened
// -----------------------------------------------------------------------------
module mul_reduce_stage
   import mul_pipe_unit_pkg::*;
#(
   parameter int N  = 2,
   parameter int DW = 64,
   parameter int SW = 6
) (
   input  logic                    clk,
   input  logic                    nRST,
   input  logic                    hold_i,
   input  logic                    flush_i,
   input  logic                    valid_i,
   input  logic [SW-1:0]           side_i,
   input  logic [N*DW-1:0]         pp_i,
   output logic                    valid_o,
   output logic [SW-1:0]           side_o,
   output logic [(N/2)*DW-1:0]     sum_o
);

   logic [(N/2)*DW-1:0] sum_d;
   logic [(N/2)*DW-1:0] sum_q;
   logic                valid_q;
   logic [SW-1:0]       side_q;

   // Pairwise sums; DW-bit wrap arithmetic is intended.
   always_comb begin
      sum_d = '0;
      for (int i = 0; i < N / 2; i++) begin
         sum_d[i*DW +: DW] = pp_i[i*DW +: DW] + pp_i[(i + N / 2)*DW +: DW];
      end
   end

   // Level register: flush kills the valid bit even while held.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         valid_q <= 1'b0;
         side_q  <= '0;
         sum_q   <= '0;
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (!hold_i) begin
         valid_q <= valid_i;
         side_q  <= side_i;
         sum_q   <= sum_d;
      end
   end

   assign valid_o = valid_q;
   assign side_o  = side_q;
   assign sum_o   = sum_q;

endmodule

// File: rtl/mul_pipe_unit.sv
// -----------------------------------------------------------------------------
// mul_pipe_unit
// Fully pipelined tagged integer multiplier for the Tomasulo back end.
// Stage 0 registers WIDTH partial products of the operand magnitudes; then
// log2(WIDTH) mul_reduce_stage levels fold them into one 2*WIDTH-bit product.
// The sign fix-up and half select are combinational on the last level.
// Latency LAT = log2(WIDTH)+1 cycles, one operation per cycle, FIFO order.
// Ports:
//   clk, nRST                 clock, asynchronous active-low reset
//   in_valid/in_ready         issue handshake (in_ready = !stall)
//   in_a, in_b, in_tag        operands and destination tag
//   in_signed, in_high        operand signedness, product half select
//   flush                     drop every in-flight op (and any same-cycle offer)
//   out_valid/out_ready       result handshake toward the CDB arbiter
//   out_result, out_tag       selected product half and its tag
//   busy                      any valid operation in the pipe
// Optional (macro MUL_PERF_CNT_EN):
//   perf_ops                  count of output transfers
//   perf_stall                count of stalled cycles
// -----------------------------------------------------------------------------
module mul_pipe_unit
   import mul_pipe_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_signed,
   input  logic             in_high,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
`ifdef MUL_PERF_CNT_EN
   ,
   output logic [31:0]      perf_ops,
   output logic [31:0]      perf_stall
`endif
);

   localparam int LOG2W  = clog2(WIDTH);
   localparam int LAT    = LOG2W + 1;
   localparam int DW     = 2 * WIDTH;
   localparam int SW     = TAG_W + 2;
   // All tree levels packed back to back: level l starts at entry 2W-2*(W>>l).
   localparam int TREE_N = 2 * WIDTH - 1;

   logic [MODE_W-1:0]     mode_s;
   logic                  a_neg_s, b_neg_s;
   logic [WIDTH-1:0]      a_mag_s, b_mag_s;
   logic [WIDTH*DW-1:0]   pp_d, pp_q;
   logic [SW-1:0]         side0_d, side0_q;
   logic                  valid0_q;
   logic                  stall_s, accept_s;
   logic [TREE_N*DW-1:0]  tree_s;
   logic [LAT-1:0]        valid_s;
   logic [LAT-1:0][SW-1:0] side_s;
   logic [DW-1:0]         fsum_s, prod_s;

   assign mode_s[MODE_SIGNED] = in_signed;
   assign mode_s[MODE_HIGH]   = in_high;

   assign stall_s  = valid_s[LAT-1] & ~out_ready;
   assign in_ready = ~stall_s;
   assign accept_s = in_valid & in_ready & ~flush;

   // Operand magnitudes and partial products. The most negative value negates
   // to itself, which read as unsigned is exactly its magnitude.
   always_comb begin
      a_neg_s = mode_s[MODE_SIGNED] & in_a[WIDTH-1];
      b_neg_s = mode_s[MODE_SIGNED] & in_b[WIDTH-1];
      if (a_neg_s) begin
         a_mag_s = (~in_a) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         a_mag_s = in_a;
      end
      if (b_neg_s) begin
         b_mag_s = (~in_b) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         b_mag_s = in_b;
      end
      pp_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (b_mag_s[i]) begin
            pp_d[i*DW +: DW] = {{WIDTH{1'b0}}, a_mag_s} << i;
         end else begin
            pp_d[i*DW +: DW] = '0;
         end
      end
      side0_d = {in_tag, mode_s[MODE_HIGH], a_neg_s ^ b_neg_s};
   end

   // Stage 0 register; data only loads on an accepted operation.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         valid0_q <= 1'b0;
         pp_q     <= '0;
         side0_q  <= '0;
      end else if (flush) begin
         valid0_q <= 1'b0;
      end else if (!stall_s) begin
         valid0_q <= accept_s;
         if (accept_s) begin
            pp_q    <= pp_d;
            side0_q <= side0_d;
         end
      end
   end

   assign tree_s[WIDTH*DW-1:0] = pp_q;
   assign valid_s[0]           = valid0_q;
   assign side_s[0]            = side0_q;

   for (genvar l = 0; l < LOG2W; l++) begin : g_red
      localparam int NIN     = WIDTH >> l;
      localparam int OFF_IN  = 2 * WIDTH - 2 * NIN;
      localparam int OFF_OUT = OFF_IN + NIN;
      mul_reduce_stage #(
         .N  (NIN),
         .DW (DW),
         .SW (SW)
      ) u_stage (
         .clk     (clk),
         .nRST    (nRST),
         .hold_i  (stall_s),
         .flush_i (flush),
         .valid_i (valid_s[l]),
         .side_i  (side_s[l]),
         .pp_i    (tree_s[OFF_IN*DW +: NIN*DW]),
         .valid_o (valid_s[l+1]),
         .side_o  (side_s[l+1]),
         .sum_o   (tree_s[OFF_OUT*DW +: (NIN/2)*DW])
      );
   end

   // Sign fix-up and half select on the final registered sum; zero negates
   // to zero so there is no negative-zero case.
   always_comb begin
      fsum_s = tree_s[(TREE_N-1)*DW +: DW];
      if (side_s[LAT-1][SIDE_NEG]) begin
         prod_s = (~fsum_s) + {{(DW-1){1'b0}}, 1'b1};
      end else begin
         prod_s = fsum_s;
      end
      if (side_s[LAT-1][SIDE_HIGH]) begin
         out_result = prod_s[DW-1:WIDTH];
      end else begin
         out_result = prod_s[WIDTH-1:0];
      end
   end

   assign out_valid = valid_s[LAT-1];
   assign out_tag   = side_s[LAT-1][SW-1:SIDE_TAG];
   assign busy      = |valid_s;

`ifdef MUL_PERF_CNT_EN
   logic [31:0] perf_ops_q, perf_stall_q;

   // Event counters; wrap naturally and survive flush.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         perf_ops_q   <= 32'd0;
         perf_stall_q <= 32'd0;
      end else begin
         if (out_valid && out_ready) begin
            perf_ops_q <= perf_ops_q + 32'd1;
         end
         if (stall_s) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif

endmodule

// File: doc/mul_pipe_unit.md
Name: mul_pipe_unit

Overview:
Parametrised, fully pipelined integer multiply functional unit for the Tomasulo back end, sitting between the multiply reservation station and the CDB arbiter.
- Accepts one operation per cycle with a tag; returns the tagged result after a fixed latency.
- Adds signed/unsigned and low/high-half modes, output backpressure and flush, none of which the single-issue multiplier had.
- Uses a registered partial-product stage followed by a log2 adder-reduction tree.

Parameters:
WIDTH, 32, operand width; power of two, >= 4
TAG_W, 4, reservation-station tag width
LAT, log2(WIDTH)+1, derived (localparam) pipeline latency in cycles; 6 at WIDTH=32

Ports:
clk  in  1  clock
nRST  in  1  asynchronous active-low reset
in_valid  in  1  operation offered
in_ready  out  1  unit can accept this cycle
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier
in_tag  in  TAG_W  destination tag
in_signed  in  1  1 = two's-complement operands, 0 = unsigned
in_high  in  1  1 = return upper WIDTH bits of product, 0 = lower
flush  in  1  discard all in-flight operations
out_valid  out  1  result available
out_ready  in  1  CDB accepts result
out_result  out  WIDTH  selected product half
out_tag  out  TAG_W  tag of out_result
busy  out  1  any valid operation in the pipe

Behaviour:
- Reset (nRST low, asynchronous): all stage valid bits and data registers cleared; out_valid=0, out_result=0, out_tag=0, busy=0; in_ready=1 once reset is released.
- Handshake:
  - accept = in_valid & in_ready & !flush.
  - Result transfers when out_valid & out_ready.
- Stall:
  - stall = out_valid & !out_ready.
  - When stalled, every stage holds and in_ready=0 (in_ready = !stall, combinational).
  - Bubbles are not compressed while stalled.
- Stage 0 (on accept):
  - If in_signed, take magnitudes of in_a/in_b; record neg = sign(a)^sign(b).
  - Register WIDTH partial products, each 2*WIDTH wide: pp[i] = b_mag[i] ? a_mag<<i : 0.
  - Register tag, neg, in_high and valid alongside.
- Reduction stages 1..log2(WIDTH): each sums pairs, pp[i]+pp[i+N/2], halving the count; 2*WIDTH-bit wrap arithmetic. Sideband fields travel with the data.
- Output select is combinational on the final sum: negate if neg, then take bits [2W-1:W] if high else [W-1:0]. out_result/out_tag are registered outputs of the last stage.
- Latency: an operation accepted at edge k with no stall presents out_valid after edge k+LAT-1, i.e. LAT cycles including the issue cycle. Throughput is 1 per cycle; ordering is strictly FIFO.
- Boundaries:
  - Signed -2^(W-1) x -2^(W-1): magnitude 2^(W-1) fits; product is 2^(2W-2), exact.
  - Zero operand yields 0, with no -0 issue.
- flush (synchronous, highest priority): the same edge clears all valid bits, including a same-cycle offered operation, which is not accepted. out_valid is 0 the next cycle. Data registers need not clear.
- flush together with stall: flush wins; the pipe empties.
- busy = OR of all stage valid bits.

Optional Feature:
MUL_PERF_CNT_EN.
- Defined: adds ports perf_ops (out, 32) and perf_stall (out, 32).
  - perf_ops increments on each output transfer.
  - perf_stall increments each cycle stall=1.
  - Both wrap at 2^32, reset to 0 on nRST, and are not cleared by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header (alongside the existing state defines): a clog2 function, and mode bit positions (MODE_SIGNED, MODE_HIGH) for reservation-station encoding.
- One natural sub-module: mul_reduce_stage. Parameters are N inputs and width 2W. It holds N/2 registered adders plus the sideband/valid register, with a hold enable. The top level instantiates a generate chain of these.

Test Plan:
1. Unsigned 7 x 6, low, tag 3, out_ready=1 -> out_valid exactly LAT=6 cycles after issue; result 42, tag 3.
2. Signed -3 x 5 -> low 0xFFFFFFF1, high 0xFFFFFFFF; signed 0x80000000 x 0x80000000 high -> 0x40000000.
3. Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> low 0x00000001, high 0xFFFFFFFE.
4. Issue 8 back-to-back ops (a=i+1, b=2, tags 0..7) with out_ready held low for 3 cycles mid-stream -> all 8 results 2..16 delivered in tag order, none lost or duplicated; in_ready=0 exactly during stall.
5. Issue 4 ops, assert flush on cycle 3 together with in_valid -> no out_valid for any of the 5; busy=0 next cycle; a subsequent op completes normally.
6. Assert nRST low mid-stream, asynchronously between edges -> out_valid/busy drop immediately; after release, a single 2x2 returns 4 with correct latency.
